// File: rtl/dpe_accum_pkg.sv
// ============================================================================
// Module   : dpe_accum_pkg
// Purpose  : Shared widths and requantization helpers for dpe_accum_quant.
//            DPE_ACCUM_BIAS_EN widens the accumulator by one bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dpe_accum_pkg;

    localparam int unsigned DPE_OPREC      = 32;
    localparam int unsigned DPE_MAX_CHUNKS = 64;
    localparam int unsigned DPE_OUTW       = 8;
    localparam int unsigned DPE_FIFO_DEPTH = 8;
`ifdef DPE_ACCUM_BIAS_EN
    localparam int unsigned DPE_BIAS_W     = 1;
`else
    localparam int unsigned DPE_BIAS_W     = 0;
`endif
    localparam int unsigned DPE_ACCW   = DPE_OPREC + $clog2(DPE_MAX_CHUNKS) + DPE_BIAS_W;
    localparam int unsigned DPE_CHUNKW = $clog2(DPE_MAX_CHUNKS) + 1;
    localparam int unsigned DPE_SHW    = $clog2(DPE_ACCW);

    // Working width for the helpers; wider than ACCW+1 so the rounding add cannot wrap.
    localparam int unsigned DPE_CALCW  = 64;
    typedef logic signed [DPE_CALCW-1:0] calc_t;

    function automatic calc_t f_round_shift(input calc_t acc, input int unsigned shift);
        calc_t rnd;
        rnd = '0;
        if (shift != 0) begin
            rnd = calc_t'(1) << (shift - 1);
        end
        return (acc + rnd) >>> shift;
    endfunction

    function automatic calc_t f_sat(input calc_t r, input int unsigned outw);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) << (outw - 1)) - calc_t'(1);
        lo = -hi - calc_t'(1);
        if (r > hi) begin
            return hi;
        end
        if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dpe_out_fifo.sv
// ============================================================================
// Module   : dpe_out_fifo
// Purpose  : Synchronous FIFO, no fall-through, head held in a register array.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dpe_out_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             w_push;
    logic             w_pop;

    assign o_valid = (cnt_q != '0);
    assign o_full  = (cnt_q == CW'(DEPTH));
    assign o_count = cnt_q;
    assign o_data  = mem_q[rd_q];

    // A pop frees a slot in the same cycle, so a push against a full FIFO still lands.
    assign w_pop  = i_pop && o_valid;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_q] <= i_data;
                wr_q        <= wr_q + AW'(1);
            end
            if (w_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dpe_accum_quant.sv
// ============================================================================
// Module   : dpe_accum_quant
// Purpose  : Accumulates engine partial sums, requantizes and buffers results.
//            Optional macro DPE_ACCUM_BIAS_EN adds a per-output bias input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dpe_accum_quant
    import dpe_accum_pkg::*;
#(
    parameter int unsigned OPREC      = DPE_OPREC,
    parameter int unsigned MAX_CHUNKS = DPE_MAX_CHUNKS,
    parameter int unsigned ACCW       = OPREC + $clog2(MAX_CHUNKS) + DPE_BIAS_W,
    parameter int unsigned OUTW       = DPE_OUTW,
    parameter int unsigned FIFO_DEPTH = DPE_FIFO_DEPTH,
    parameter int unsigned CHUNKW     = $clog2(MAX_CHUNKS) + 1,
    parameter int unsigned SHW        = $clog2(ACCW)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic signed [OPREC-1:0] i_result,
    input  logic [CHUNKW-1:0]      i_cfg_chunks,
    input  logic [SHW-1:0]         i_cfg_shift,
    input  logic                   i_cfg_relu,
`ifdef DPE_ACCUM_BIAS_EN
    input  logic signed [OPREC-1:0] i_bias,
`endif
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic signed [OUTW-1:0] o_data,
    output logic                   o_almost_full,
    output logic                   o_overflow,
    output logic                   o_busy
);

    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

    logic [CHUNKW-1:0]      cnt_q,    cnt_d;
    logic [CHUNKW-1:0]      chunks_q, chunks_d;
    logic [SHW-1:0]         shift_q,  shift_d;
    logic                   relu_q,   relu_d;
    logic signed [ACCW-1:0] acc_q,    acc_d;
    logic                   s1_valid_q, s1_valid_d;
    logic                   s2_valid_q;
    logic [OUTW-1:0]        s2_data_q;
    logic                   ovf_q;

    logic [CHUNKW-1:0]      w_cnt_inc;
    logic [OUTW-1:0]        w_sat;
    logic [OUTW-1:0]        w_res;
    logic [FCW-1:0]         w_count;
    logic                   w_full;
    logic                   w_pop;
    logic [OUTW-1:0]        w_fifo_data;

    // Stage 1: config latches only on the first partial of a group.
    always_comb begin
        cnt_d      = cnt_q;
        chunks_d   = chunks_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        acc_d      = acc_q;
        s1_valid_d = 1'b0;
        w_cnt_inc  = cnt_q + CHUNKW'(1);
        if (i_valid) begin
            if (cnt_q == '0) begin
                chunks_d = (i_cfg_chunks == '0) ? CHUNKW'(1) : i_cfg_chunks;
                shift_d  = i_cfg_shift;
                relu_d   = i_cfg_relu;
`ifdef DPE_ACCUM_BIAS_EN
                acc_d    = ACCW'(i_bias) + ACCW'(i_result);
`else
                acc_d    = ACCW'(i_result);
`endif
            end else begin
                acc_d = acc_q + ACCW'(i_result);
            end
            if (w_cnt_inc == chunks_d) begin
                cnt_d      = '0;
                s1_valid_d = 1'b1;
            end else begin
                cnt_d = w_cnt_inc;
            end
        end
    end

    // Saturated value fits OUTW, so its top bit is the sign used for ReLU.
    assign w_sat = OUTW'(f_sat(f_round_shift(calc_t'(acc_q), 32'(shift_q)), OUTW));
    assign w_res = (relu_q && w_sat[OUTW-1]) ? '0 : w_sat;

    assign w_pop = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            chunks_q   <= CHUNKW'(1);
            shift_q    <= '0;
            relu_q     <= 1'b0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            chunks_q   <= chunks_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            acc_q      <= acc_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= w_res;
            end
            if (s2_valid_q && w_full && !w_pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    dpe_out_fifo #(
        .WIDTH (OUTW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (s2_valid_q),
        .i_data  (s2_data_q),
        .i_pop   (w_pop),
        .o_valid (o_valid),
        .o_data  (w_fifo_data),
        .o_count (w_count),
        .o_full  (w_full)
    );

    assign o_data        = w_fifo_data;
    assign o_almost_full = (w_count >= FCW'(FIFO_DEPTH - 2));
    assign o_overflow    = ovf_q;
    assign o_busy        = (cnt_q != '0);

endmodule

`default_nettype wire

// File: doc/dpe_accum_quant.md
Name: dpe_accum_quant

Overview:
- Sits directly downstream of the dot-product engine in the MLP datapath.
- Consumes the engine's stream of signed partial sums (o_valid/o_result) and accumulates a programmable number of consecutive partials into one neuron pre-activation; this covers vectors longer than one engine pass.
- Each finished sum is round-shifted, saturated and optionally ReLU'd, then buffered in a small output FIFO with a valid/ready interface toward the activation writer.
- The engine has no backpressure, so the block exports an almost-full flag that the controller uses to stop issuing.

Parameters:
OPREC, 32, width of incoming partial sums (signed)
MAX_CHUNKS, 64, maximum partials per output
ACCW, OPREC+$clog2(MAX_CHUNKS), accumulator width (overflow-free by construction)
OUTW, 8, output element width (signed)
FIFO_DEPTH, 8, output FIFO entries (power of 2, >=4)
CHUNKW, $clog2(MAX_CHUNKS)+1, width of chunk-count config
SHW, $clog2(ACCW), width of shift config

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
i_valid  in  1  partial-sum valid (from engine o_valid)
i_result  in  OPREC  signed partial sum
i_cfg_chunks  in  CHUNKW  partials per output; 0 treated as 1
i_cfg_shift  in  SHW  requantization right-shift
i_cfg_relu  in  1  1 = clamp negative outputs to 0
i_bias  in  OPREC  signed bias; present only with DPE_ACCUM_BIAS_EN
o_valid  out  1  FIFO head valid
i_ready  in  1  downstream accepts head
o_data  out  OUTW  signed quantized result
o_almost_full  out  1  FIFO count >= FIFO_DEPTH-2
o_overflow  out  1  sticky: result dropped because FIFO full
o_busy  out  1  group in progress (chunk counter != 0)

Behaviour:
- Reset values: o_valid=0, o_data=0, o_almost_full=0, o_overflow=0, o_busy=0. FIFO empty, chunk counter 0, both pipeline stages invalid. Reset mid-group discards the partial accumulation.
- Config latch: i_cfg_chunks, i_cfg_shift and i_cfg_relu (and i_bias) are sampled on the i_valid cycle with counter==0. Changes mid-group are ignored until the next group.
- Stage 1 (accumulate):
  - On i_valid with counter==0: acc <= sext(i_result).
  - Otherwise on i_valid: acc <= acc + sext(i_result).
  - Counter increments; it wraps to 0 on the last partial (count == latched chunks), which marks stage-1 output valid next cycle.
  - No i_valid: state holds.
- Stage 2 (requantize), registered:
  - r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift. Arithmetic shift, round-half-up; rounding add performed at ACCW+1 bits.
  - Saturate r to [-2^(OUTW-1), 2^(OUTW-1)-1].
  - If relu and negative, result is 0.
- FIFO push occurs when stage-2 output is valid.
- Latency: last partial accepted in cycle T, result in stage 2 at T+2, o_valid=1 in T+3 when the FIFO was empty. Throughput is one result per cycle with chunks=1.
- FIFO:
  - Pop on o_valid && i_ready. o_data is the head, held stable while o_valid && !i_ready.
  - Push while full with no simultaneous pop: result dropped, o_overflow set (cleared only by rst).
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: o_valid is not asserted that cycle, since there is no fall-through.
- o_almost_full is combinational on the FIFO count. Threshold FIFO_DEPTH-2 covers the two in-flight pipeline stages.

Optional Feature:
DPE_ACCUM_BIAS_EN:
- Defined: i_bias port exists. At group start, acc <= sext(i_bias) + sext(i_result), so bias is added exactly once per output, before rounding. ACCW grows by 1 bit.
- Undefined: port absent; acc initialises to the first partial alone.

Decomposition:
- Package dpe_accum_pkg: ACCW/CHUNKW/SHW derivation constants, plus functions f_round_shift(acc, shift) and f_sat(r, OUTW).
- One sub-module, dpe_out_fifo: synchronous FIFO, registered output, count output, parameterised on width and depth.

Test Plan:
1. Accumulate and round: chunks=4, shift=2, relu=0; partials 100, 200, -50, 30 -> one output 70 ((280+2)>>2). o_valid rises 3 cycles after the 4th partial.
2. Saturation and ReLU:
   - chunks=1, shift=0; partial 1000 -> 127.
   - Partial -1000 -> -128.
   - Same with relu=1 -> 0.
3. Full FIFO: FIFO_DEPTH=8, i_ready=0, chunks=1; 9 partials -> 8 stored, o_almost_full from count 6, o_overflow=1. Then i_ready=1 drains exactly 8 results in order.
4. Full with concurrent pop: FIFO full, i_ready=1, one push -> accepted, o_overflow stays 0, count stays 8.
5. Reset mid-group: chunks=4, 2 partials (10, 20), assert rst one cycle, then 4 partials of 1 with shift=0 -> output 4; o_busy 0 after rst.
6. Config mid-group: chunks=2 latched; i_cfg_chunks changed to 3 after the first partial -> output after 2 partials. The next group uses 3.
